cnn_mac_sched: RTL and testbench
================================

CNN_MAC_SCHED -- requirements
Module: cnn_mac_sched

Interface
REQ-001 SHALL provide parameter NTAP, default 9, taps per output (legal 1..64).
REQ-002 SHALL provide parameter ACC_W, default 24, accumulator/output width (≥ 20+ceil(log2 NTAP)).
REQ-003 SHALL have port ap_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port ap_rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ap_start in 1; ap_done, ap_idle, ap_ready out 1 each; ap_ctrl_hs block-level handshake.
REQ-006 SHALL have in_a_dout in 14 signed pixel; in_a_empty_n in 1; in_a_read out 1 (ap_fifo read side).
REQ-007 SHALL have in_b_dout in 6 unsigned weight; in_b_empty_n in 1; in_b_read out 1.
REQ-008 SHALL have out_din out ACC_W signed result; out_full_n in 1; out_write out 1 (ap_fifo write side).

Function
REQ-009 SHALL contain one 14s x 6u multiplier, product = signed(a) * signed({1'b0,b}), 20-bit signed, registered once (P_REG).
REQ-010 SHALL implement states IDLE, RUN, FLUSH, WRITE.
REQ-011 IDLE: ap_idle=1; ap_start=1 moves to RUN next cycle and clears tap counter, accumulator, P_REG valid.
REQ-012 RUN: in_a_read=in_b_read=1 only in cycles where in_a_empty_n=1 and in_b_empty_n=1 and taps read < NTAP; both reads always coincide.
REQ-013 RUN: a cycle with either FIFO empty SHALL issue no read and not advance the tap counter (bubble).
REQ-014 Each registered product SHALL be added, sign-extended, into accumulator on the following cycle; sum wraps modulo 2^ACC_W.
REQ-015 After the NTAP-th read, RUN moves to FLUSH; FLUSH accumulates the last product then moves to WRITE.
REQ-016 WRITE: out_write=1 and out_din=final result while out_full_n=1; that cycle also asserts ap_done=1 and ap_ready=1 (single-cycle pulses), next state IDLE.
REQ-017 WRITE with out_full_n=0: out_write=0, out_din held stable, state held, ap_done withheld.
REQ-018 Latency with no bubbles/backpressure: ap_done asserted NTAP+2 cycles after the cycle ap_start is sampled in IDLE.
REQ-019 ap_start held high through ap_done SHALL start a new job from IDLE the cycle after; ap_start outside IDLE is ignored.
REQ-020 NTAP=1: RUN holds for exactly one read, then FLUSH, WRITE.
REQ-021 in_*_read and out_write SHALL never be asserted in IDLE, FLUSH.

Reset
REQ-022 ap_rst_n=0 at a rising edge: state IDLE, ap_idle=1, ap_done=0, ap_ready=0, in_a_read=0, in_b_read=0, out_write=0, out_din=0, accumulator=0, counter=0.
REQ-023 Reset mid-job SHALL discard partial sum; no out_write for the aborted job; next ap_start begins from zero.

Configuration
REQ-024 Macro CNN_MAC_RELU_EN defined: final result < 0 SHALL be written as 0 (ReLU); positive results unchanged.
REQ-025 Macro CNN_MAC_RELU_EN undefined: raw signed accumulator written unchanged; no ReLU logic present.

Verification
REQ-026 NTAP=9, a=100, b=3 every tap, FIFOs never empty, out_full_n=1 -> single out_write, out_din=2700, ap_done at start+11 cycles.
REQ-027 a=-8192, b=63 x9 -> out_din=-4644864 (24-bit); with CNN_MAC_RELU_EN -> out_din=0.
REQ-028 Same data as REQ-026 with in_a_empty_n low on alternate cycles -> reads only when both non-empty, out_din=2700, ap_done at start+20.
REQ-029 out_full_n=0 for 5 cycles on WRITE entry -> out_write=0, out_din stable, ap_done delayed exactly 5 cycles, then 2700 written once.
REQ-030 ap_rst_n=0 after 4 taps -> all outputs reset values next cycle, ap_idle=1; subsequent job with REQ-026 data -> 2700.
REQ-031 ap_start held high continuously, 3 jobs back-to-back -> 3 out_write pulses, each exactly NTAP+3 cycles apart.

Source files
------------

// File: rtl/cnn_mac_sched.sv
// Convolution tap MAC: reads NTAP pixel/weight pairs from ap_fifo inputs, accumulates, writes one result.
// Latency NTAP+2 cycles from start to done; input bubbles stall the tap count, out_full_n=0 holds WRITE.
// Optional build macro CNN_MAC_RELU_EN clamps negative results to zero.
module cnn_mac_sched #(
    parameter int NTAP  = 9,
    parameter int ACC_W = 24
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    output logic                    ap_ready,
    input  logic [13:0]             in_a_dout,
    input  logic                    in_a_empty_n,
    output logic                    in_a_read,
    input  logic [5:0]              in_b_dout,
    input  logic                    in_b_empty_n,
    output logic                    in_b_read,
    output logic [ACC_W-1:0]        out_din,
    input  logic                    out_full_n,
    output logic                    out_write
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, WRITE} state_t;

    localparam logic [6:0] NTAP_C = 7'(NTAP);
    localparam logic [6:0] LAST_C = 7'(NTAP - 1);

    state_t                  state;
    logic [6:0]              taps;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] result;
    logic signed [19:0]      a_ext;
    logic signed [19:0]      b_ext;
    logic signed [19:0]      prod;
    logic signed [19:0]      p_reg;
    logic                    p_vld;
    logic                    rd;
    logic                    wr;

    // Both operands widened to 20 bits so the multiply is evaluated at full product width.
    assign a_ext = 20'($signed(in_a_dout));
    assign b_ext = {14'd0, in_b_dout};
    assign prod  = a_ext * b_ext;

    assign p_ext   = ACC_W'(p_reg);
    assign acc_sum = p_vld ? acc + p_ext : acc;

`ifdef CNN_MAC_RELU_EN
    assign result = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
    assign result = acc_sum;
`endif

    // FIFO strobes must follow empty_n/full_n in the same cycle, so they stay combinational.
    assign rd = (state == RUN) && in_a_empty_n && in_b_empty_n && (taps < NTAP_C);
    assign wr = (state == WRITE) && out_full_n;

    assign in_a_read = rd;
    assign in_b_read = rd;
    assign out_write = wr;
    assign ap_done   = wr;
    assign ap_ready  = wr;
    assign ap_idle   = (state == IDLE);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state   <= IDLE;
            taps    <= '0;
            acc     <= '0;
            p_reg   <= '0;
            p_vld   <= 1'b0;
            out_din <= '0;
        end else begin
            p_vld <= rd;
            if (rd) begin
                p_reg <= prod;
            end
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        state <= RUN;
                        taps  <= '0;
                        acc   <= '0;
                        p_vld <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    if (rd) begin
                        taps <= taps + 7'd1;
                        if (taps == LAST_C) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    acc     <= acc_sum;
                    out_din <= result;
                    state   <= WRITE;
                end
                WRITE: begin
                    if (out_full_n) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_mac_sched.sv
// Directed bench for cnn_mac_sched: NTAP=9 main instance plus an NTAP=1 instance on shared inputs.
module tb_cnn_mac_sched;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [13:0] in_a_dout;
    logic        in_a_empty_n, in_a_read;
    logic [5:0]  in_b_dout;
    logic        in_b_empty_n, in_b_read;
    logic [23:0] out_din;
    logic        out_full_n, out_write;

    logic        ap_done1, ap_idle1, ap_ready1;
    logic        in_a_read1, in_b_read1;
    logic [23:0] out_din1;
    logic        out_write1;

    int errors = 0;
    int checks = 0;
    int n1_done, n1_reads, n1_res;

    always #5 ap_clk = ~ap_clk;

    cnn_mac_sched #(.NTAP(9), .ACC_W(24)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .in_a_dout(in_a_dout), .in_a_empty_n(in_a_empty_n), .in_a_read(in_a_read),
        .in_b_dout(in_b_dout), .in_b_empty_n(in_b_empty_n), .in_b_read(in_b_read),
        .out_din(out_din), .out_full_n(out_full_n), .out_write(out_write)
    );

    cnn_mac_sched #(.NTAP(1), .ACC_W(24)) dut1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done1), .ap_idle(ap_idle1), .ap_ready(ap_ready1),
        .in_a_dout(in_a_dout), .in_a_empty_n(in_a_empty_n), .in_a_read(in_a_read1),
        .in_b_dout(in_b_dout), .in_b_empty_n(in_b_empty_n), .in_b_read(in_b_read1),
        .out_din(out_din1), .out_full_n(out_full_n), .out_write(out_write1)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: clean run, 1: in_a_empty_n low on odd cycles, 2: out_full_n low for 5 cycles from WRITE entry.
    // Entered and left at posedge+1; inputs change there, outputs are sampled one unit later.
    task automatic run_job(input string tag, input logic [13:0] a, input logic [5:0] b,
                           input int mode, input int exp_res, input int exp_lat);
        int cyc = 0;
        int done_cyc = -1;
        int reads = 0;
        int writes = 0;
        int mism = 0;
        int res = 0;
        logic [23:0] held = '0;
        n1_done  = -1;
        n1_reads = 0;
        n1_res   = 0;
        in_a_dout = a;
        in_b_dout = b;
        ap_start  = 1'b1;
        while (done_cyc < 0 && cyc < 100) begin
            if (cyc == 1) ap_start = 1'b0;
            in_a_empty_n = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            out_full_n   = !(mode == 2 && cyc >= 11 && cyc < 16);
            #1;
            if (in_a_read) reads++;
            if (in_a_read !== in_b_read) mism++;
            if (ap_done !== out_write || ap_ready !== out_write) mism++;
            if (mode == 2 && cyc == 11) held = out_din;
            if (mode == 2 && cyc >= 11 && cyc < 16) begin
                check({tag, "_stall_wr"}, int'(out_write), 0);
                check({tag, "_stall_din"}, int'(out_din), int'(held));
            end
            if (out_write) begin
                writes++;
                res = $signed(out_din);
            end
            if (ap_done) done_cyc = cyc;
            if (in_a_read1) n1_reads++;
            if (out_write1) begin
                n1_done = cyc;
                n1_res  = $signed(out_din1);
            end
            @(posedge ap_clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, done_cyc, exp_lat);
        check({tag, "_reads"}, reads, 9);
        check({tag, "_writes"}, writes, 1);
        check({tag, "_result"}, res, exp_res);
        check({tag, "_strobe_mismatch"}, mism, 0);
        #1;
        check({tag, "_idle_after"}, int'(ap_idle), 1);
        check({tag, "_no_extra_wr"}, int'(out_write), 0);
    endtask

    initial begin
        int wcnt;
        int wc[3];
        int writes;
        int pos_exp;
        ap_rst_n     = 1'b0;
        ap_start     = 1'b0;
        in_a_dout    = '0;
        in_b_dout    = '0;
        in_a_empty_n = 1'b1;
        in_b_empty_n = 1'b1;
        out_full_n   = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_idle", int'(ap_idle), 1);
        check("rst_done", int'(ap_done), 0);
        check("rst_ready", int'(ap_ready), 0);
        check("rst_read", int'(in_a_read | in_b_read), 0);
        check("rst_write", int'(out_write), 0);
        check("rst_din", int'(out_din), 0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        run_job("basic", 14'd100, 6'd3, 0, 2700, 11);
        check("ntap1_latency", n1_done, 3);
        check("ntap1_reads", n1_reads, 1);
        check("ntap1_result", n1_res, 300);

`ifdef CNN_MAC_RELU_EN
        run_job("neg_min", 14'h2000, 6'd63, 0, 0, 11);
`else
        run_job("neg_min", 14'h2000, 6'd63, 0, -4644864, 11);
`endif
        pos_exp = 4644297;
        run_job("pos_max", 14'd8191, 6'd63, 0, pos_exp, 11);
        run_job("bubbles", 14'd100, 6'd3, 1, 2700, 20);
        run_job("backpress", 14'd100, 6'd3, 2, 2700, 16);

        // Abort a job after four taps.
        in_a_dout = 14'd100;
        in_b_dout = 6'd3;
        ap_start  = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (3) begin
            @(posedge ap_clk);
            #1;
        end
        check("abort_mid_read", int'(in_a_read), 1);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        check("abort_idle", int'(ap_idle), 1);
        check("abort_done", int'(ap_done), 0);
        check("abort_read", int'(in_a_read | in_b_read), 0);
        check("abort_write", int'(out_write), 0);
        check("abort_din", int'(out_din), 0);
        ap_rst_n = 1'b1;
        writes = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge ap_clk);
            #1;
            if (out_write) writes++;
        end
        check("abort_no_write", writes, 0);
        run_job("after_abort", 14'd100, 6'd3, 0, 2700, 11);

        // Back-to-back jobs with ap_start held high.
        ap_start = 1'b1;
        wcnt = 0;
        wc = '{default: -1};
        for (int cyc = 0; cyc < 50; cyc++) begin
            #1;
            if (out_write) begin
                if (wcnt < 3) begin
                    wc[wcnt] = cyc;
                    check("b2b_result", $signed(out_din), 2700);
                end
                wcnt++;
                if (wcnt == 3) ap_start = 1'b0;
            end
            @(posedge ap_clk);
            #1;
        end
        check("b2b_count", wcnt, 3);
        check("b2b_first", wc[0], 11);
        check("b2b_gap1", wc[1] - wc[0], 12);
        check("b2b_gap2", wc[2] - wc[1], 12);
        check("b2b_idle_end", int'(ap_idle), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
